// File: rtl/stream_rr_mux.sv
// Packet-granular round-robin N-to-1 stream mux with one registered output stage.
// Locks onto the winning source from first beat to last beat, then rearbitrates.
module stream_rr_mux #(
    parameter int NUM_INPUTS     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_LOG_INPUTS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_INPUTS-1:0]                 src_val,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] src_data,
    input  logic [NUM_INPUTS-1:0]                 src_last,
    output logic [NUM_INPUTS-1:0]                 src_rdy,
    output logic                                  dst_val,
    output logic [DATA_WIDTH-1:0]                 dst_data,
    output logic                                  dst_last,
    output logic [NUM_LOG_INPUTS-1:0]             dst_sel,
    input  logic                                  dst_rdy,
    output logic                                  dbg_state,
    output logic [NUM_LOG_INPUTS-1:0]             dbg_rr_ptr
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [NUM_LOG_INPUTS-1:0] LAST_IDX = NUM_LOG_INPUTS'(NUM_INPUTS - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_LOG_INPUTS-1:0] r_grant;
    logic [NUM_LOG_INPUTS-1:0] w_grant_nxt;
    logic [NUM_LOG_INPUTS-1:0] r_rr_ptr;
    logic [NUM_LOG_INPUTS-1:0] w_rr_nxt;
    logic [NUM_LOG_INPUTS-1:0] w_arb_idx;
    logic [NUM_LOG_INPUTS-1:0] w_grant_inc;
    logic                      w_arb_found;
    logic                      w_take;
    logic                      w_accept;
    logic                      w_sel_val;
    logic                      w_sel_last;
    logic [DATA_WIDTH-1:0]     w_sel_data;

    logic                      r_dst_val;
    logic [DATA_WIDTH-1:0]     r_dst_data;
    logic                      r_dst_last;
    logic [NUM_LOG_INPUTS-1:0] r_dst_sel;

    // Index k positions after base, wrapping at NUM_INPUTS rather than a power of two.
    function automatic logic [NUM_LOG_INPUTS-1:0] rr_index(input logic [NUM_LOG_INPUTS-1:0] base,
                                                           input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        return NUM_LOG_INPUTS'(sum);
    endfunction

    // Scan from the far end back so the closest requester to rr_ptr is written last.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (src_val[rr_index(r_rr_ptr, k)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = rr_index(r_rr_ptr, k);
            end
        end
    end

    assign w_sel_val   = src_val[r_grant];
    assign w_sel_data  = src_data[r_grant];
    assign w_sel_last  = src_last[r_grant];
    assign w_take      = !r_dst_val || dst_rdy;
    assign w_accept    = (r_state == ST_LOCKED) && w_sel_val && w_take;
    assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    // Ready depends only on state, grant and the output stage, never on src_val.
    always_comb begin
        src_rdy = '0;
        if (r_state == ST_LOCKED) src_rdy[r_grant] = w_take;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_grant_nxt = w_arb_idx;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_sel_last) begin
                    w_rr_nxt    = w_grant_inc;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Output stage: load on accept, clear valid once drained, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst_val  <= 1'b0;
            r_dst_data <= '0;
            r_dst_last <= 1'b0;
            r_dst_sel  <= '0;
        end else if (w_accept) begin
            r_dst_val  <= 1'b1;
            r_dst_data <= w_sel_data;
            r_dst_last <= w_sel_last;
            r_dst_sel  <= r_grant;
        end else if (r_dst_val && dst_rdy) begin
            r_dst_val  <= 1'b0;
        end
    end

    assign dst_val    = r_dst_val;
    assign dst_data   = r_dst_data;
    assign dst_last   = r_dst_last;
    assign dst_sel    = r_dst_sel;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed bench for stream_rr_mux: three instances (4, 3 and 1 inputs) share one
// set of source models; only the instance selected by act sees valid requests.
module tb_stream_rr_mux;
    localparam int W  = 8;
    localparam int EW = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]        sv;
    logic [3:0][W-1:0] sd;
    logic [3:0]        sl;
    logic              dst_rdy;
    int                act;

    logic [3:0] v4;
    logic [2:0] v3;
    logic [0:0] v1;
    assign v4 = (act == 4) ? sv : 4'b0;
    assign v3 = (act == 3) ? sv[2:0] : 3'b0;
    assign v1 = (act == 1) ? sv[0:0] : 1'b0;

    logic [3:0] d4_rdy;  logic d4_val, d4_last, d4_st;  logic [W-1:0] d4_data;  logic [1:0] d4_sel, d4_rr;
    logic [2:0] d3_rdy;  logic d3_val, d3_last, d3_st;  logic [W-1:0] d3_data;  logic [1:0] d3_sel, d3_rr;
    logic [0:0] d1_rdy;  logic d1_val, d1_last, d1_st;  logic [W-1:0] d1_data;  logic [0:0] d1_sel, d1_rr;

    stream_rr_mux #(.NUM_INPUTS(4), .DATA_WIDTH(W)) u4 (
        .clk(clk), .rst_n(rst_n), .src_val(v4), .src_data(sd), .src_last(sl), .src_rdy(d4_rdy),
        .dst_val(d4_val), .dst_data(d4_data), .dst_last(d4_last), .dst_sel(d4_sel),
        .dst_rdy(dst_rdy), .dbg_state(d4_st), .dbg_rr_ptr(d4_rr));

    stream_rr_mux #(.NUM_INPUTS(3), .DATA_WIDTH(W)) u3 (
        .clk(clk), .rst_n(rst_n), .src_val(v3), .src_data(sd[2:0]), .src_last(sl[2:0]), .src_rdy(d3_rdy),
        .dst_val(d3_val), .dst_data(d3_data), .dst_last(d3_last), .dst_sel(d3_sel),
        .dst_rdy(dst_rdy), .dbg_state(d3_st), .dbg_rr_ptr(d3_rr));

    stream_rr_mux #(.NUM_INPUTS(1), .DATA_WIDTH(W)) u1 (
        .clk(clk), .rst_n(rst_n), .src_val(v1), .src_data(sd[0:0]), .src_last(sl[0:0]), .src_rdy(d1_rdy),
        .dst_val(d1_val), .dst_data(d1_data), .dst_last(d1_last), .dst_sel(d1_sel),
        .dst_rdy(dst_rdy), .dbg_state(d1_st), .dbg_rr_ptr(d1_rr));

    // Monitor view of whichever instance is active.
    logic         m_val, m_last, m_st;
    logic [W-1:0] m_data;
    logic [1:0]   m_sel, m_rr;
    logic [3:0]   m_rdy;
    always_comb begin
        m_val = d4_val; m_data = d4_data; m_last = d4_last; m_sel = d4_sel;
        m_rr  = d4_rr;  m_st   = d4_st;   m_rdy  = d4_rdy;
        if (act == 3) begin
            m_val = d3_val; m_data = d3_data; m_last = d3_last; m_sel = d3_sel;
            m_rr  = d3_rr;  m_st   = d3_st;   m_rdy  = {1'b0, d3_rdy};
        end else if (act == 1) begin
            m_val = d1_val; m_data = d1_data; m_last = d1_last; m_sel = {1'b0, d1_sel};
            m_rr  = {1'b0, d1_rr}; m_st = d1_st; m_rdy = {3'b0, d1_rdy};
        end
    end

    // Source models and scoreboard state.
    int rem[4], idx[4], plen[4], gap[4], pause_at[4];
    int cyc;
    int n_checks = 0;
    int n_errors = 0;
    int n_stall;
    logic          hold_v;
    logic [EW-1:0] hold_b;
    logic [EW-1:0] exp_q[$];
    int            got_cyc[$];
    int            acc_cyc[$];
    logic [1:0]    got_rr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] beat(input int s, input int i, input bit last);
        return {2'(s), last, 2'(s), 6'(i)};
    endfunction

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            sv[i] = (rem[i] > 0) && (gap[i] == 0);
            sd[i] = {2'(i), 6'(idx[i])};
            sl[i] = ((idx[i] + 1) % plen[i]) == 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; idx[i] = 0; plen[i] = 1; gap[i] = 0; pause_at[i] = -1;
        end
        drive_src();
        dst_rdy = 1'b1;
        hold_v  = 1'b0;
        n_stall = 0;
        cyc     = 0;
        exp_q.delete(); got_cyc.delete(); acc_cyc.delete(); got_rr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: sample/score at negedge, then advance sources after the posedge.
    task automatic step(input logic nrdy);
        logic [3:0]    fire;
        logic [EW-1:0] exp_b;
        @(negedge clk);
        cyc++;
        if (hold_v) begin
            check("hold_val", m_val, 1);
            check("hold_beat", {m_sel, m_last, m_data}, hold_b);
        end
        hold_v = m_val && !dst_rdy;
        hold_b = {m_sel, m_last, m_data};
        if (hold_v) begin
            n_stall++;
            check("stall_rdy", m_rdy, 0);
        end
        if (gap[0] > 0 && rem[2] > 0) begin
            check("lock_rdy2", m_rdy[2], 0);
            check("lock_state", m_st, 1);
        end
        if (m_val && dst_rdy) begin
            got_cyc.push_back(cyc);
            got_rr.push_back(m_rr);
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : {EW{1'b1}};
            check("beat", {m_sel, m_last, m_data}, exp_b);
        end
        fire = sv & m_rdy;
        if (fire != 4'b0) acc_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        dst_rdy = nrdy;
        for (int i = 0; i < 4; i++) begin
            if (gap[i] > 0) gap[i]--;
            if (fire[i]) begin
                rem[i]--;
                idx[i]++;
                if (idx[i] == pause_at[i]) gap[i] = 5;
            end
        end
        drive_src();
    endtask

    initial begin
        act = 4;
        do_reset();
        #1;
        check("rst_val", m_val, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_sel", m_sel, 0);
        check("rst_rr", m_rr, 0);
        check("rst_state", m_st, 0);
        check("rst_rdy", m_rdy, 0);

        // Four sources, two 2-beat packets each, all requesting continuously.
        for (int i = 0; i < 4; i++) begin rem[i] = 4; plen[i] = 2; end
        for (int k = 0; k < 16; k++)
            exp_q.push_back(beat((k / 2) % 4, (k % 2) + 2 * (k / 8), (k % 2) == 1));
        drive_src();
        repeat (32) step(1'b1);
        check("rr_count", got_cyc.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < got_rr.size()) begin
                check("rr_ptr", got_rr[k], (k % 2 == 1) ? (((k / 2) % 4 + 1) % 4) : ((k / 2) % 4));
                if (k > 0) check("rr_gap", got_cyc[k] - got_cyc[k-1], (k % 2 == 1) ? 1 : 2);
            end
        end
        check("rr_drain", exp_q.size(), 0);

        // Backpressure: one 4-beat packet from src 1, dst_rdy pattern 1,0,0,1,...
        do_reset();
        rem[1] = 4; plen[1] = 4;
        for (int k = 0; k < 4; k++) exp_q.push_back(beat(1, k, k == 3));
        drive_src();
        for (int p = 0; p < 24; p++) step(((p + 1) % 4 == 0) || ((p + 1) % 4 == 3));
        check("bp_stalled", n_stall > 0, 1);
        check("bp_drain", exp_q.size(), 0);

        // Lock: src 0 pauses 5 cycles after its first beat while src 2 waits.
        do_reset();
        dst_rdy = 1'b1;
        rem[0] = 3; plen[0] = 3; pause_at[0] = 1;
        rem[2] = 1; plen[2] = 1;
        exp_q.push_back(beat(0, 0, 0));
        exp_q.push_back(beat(0, 1, 0));
        exp_q.push_back(beat(0, 2, 1));
        exp_q.push_back(beat(2, 0, 1));
        drive_src();
        repeat (20) step(1'b1);
        check("lock_drain", exp_q.size(), 0);

        // Three inputs: move rr_ptr to 2, then src 2 and src 0 request together.
        act = 3;
        do_reset();
        rem[1] = 1;
        exp_q.push_back(beat(1, 0, 1));
        drive_src();
        repeat (6) step(1'b1);
        rem[2] = 1; rem[0] = 1;
        exp_q.push_back(beat(2, 0, 1));
        exp_q.push_back(beat(0, 0, 1));
        drive_src();
        repeat (10) step(1'b1);
        check("n3_count", got_rr.size(), 3);
        if (got_rr.size() == 3) begin
            check("n3_rr_a", got_rr[0], 2);
            check("n3_rr_b", got_rr[1], 0);
            check("n3_rr_c", got_rr[2], 1);
        end
        check("n3_drain", exp_q.size(), 0);

        // Single input, back-to-back single-beat packets.
        act = 1;
        do_reset();
        rem[0] = 2; plen[0] = 1;
        exp_q.push_back(beat(0, 0, 1));
        exp_q.push_back(beat(0, 1, 1));
        drive_src();
        repeat (8) step(1'b1);
        check("n1_count", got_cyc.size(), 2);
        if (got_cyc.size() == 2 && acc_cyc.size() > 0) begin
            check("n1_latency", got_cyc[0] - acc_cyc[0], 1);
            check("n1_spacing", got_cyc[1] - got_cyc[0], 2);
        end
        check("n1_rr", m_rr, 0);

        // Async reset mid-packet with a stalled beat held on dst.
        act = 4;
        do_reset();
        dst_rdy = 1'b0;
        rem[2] = 3; plen[2] = 3;
        rem[3] = 3; plen[3] = 3;
        drive_src();
        repeat (4) step(1'b0);
        check("pre_rst_val", m_val, 1);
        check("pre_rst_sel", m_sel, 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_val", m_val, 0);
        check("arst_data", m_data, 0);
        check("arst_last", m_last, 0);
        check("arst_sel", m_sel, 0);
        check("arst_rdy", m_rdy, 0);
        check("arst_state", m_st, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_v = 1'b0;
        #1;
        check("post_rst_state", m_st, 0);
        check("post_rst_rr", m_rr, 0);
        exp_q.push_back(beat(2, 1, 0));
        exp_q.push_back(beat(2, 2, 1));
        exp_q.push_back(beat(3, 0, 0));
        exp_q.push_back(beat(3, 1, 0));
        exp_q.push_back(beat(3, 2, 1));
        dst_rdy = 1'b1;
        repeat (14) step(1'b1);
        check("post_rst_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
